// File: rtl/cart_checkout_reader.sv
// Walks every cart slot, streams one line record per occupied slot, then a grand-total record.
// Define CART_CHECKOUT_TAX_EN to add the tax_bp input and a tax record ahead of the total.
module cart_checkout_reader #(
    parameter int NUM_SLOTS = 5,
    parameter int ADDR_W    = 3,
    parameter int PRICE_W   = 16,
    parameter int QTY_W     = 8,
    parameter int TOTAL_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
`ifdef CART_CHECKOUT_TAX_EN
    input  logic [13:0]        tax_bp,
`endif
    output logic               busy,
    output logic               done,
    output logic               slot_rd_en,
    output logic [ADDR_W-1:0]  slot_addr,
    input  logic [PRICE_W-1:0] slot_price,
    input  logic [QTY_W-1:0]   slot_qty,
    output logic               rec_valid,
    input  logic               rec_ready,
    output logic [1:0]         rec_kind,
    output logic               rec_last,
    output logic [ADDR_W-1:0]  rec_index,
    output logic [PRICE_W-1:0] rec_price,
    output logic [QTY_W-1:0]   rec_qty,
    output logic [TOTAL_W-1:0] rec_amount,
    output logic [ADDR_W:0]    item_count,
    output logic               overflow
);
    localparam int AMT_W = PRICE_W + QTY_W;
    localparam logic [TOTAL_W-1:0] MAX_TOTAL = {TOTAL_W{1'b1}};

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_EVAL  = 3'd3;
    localparam logic [2:0] S_EMIT  = 3'd4;
    localparam logic [2:0] S_TAX   = 3'd5;
    localparam logic [2:0] S_TOTAL = 3'd6;
    localparam logic [2:0] S_FIN   = 3'd7;

    logic [2:0]         r_state;
    logic [ADDR_W-1:0]  r_ptr;
    logic [PRICE_W-1:0] r_price;
    logic [QTY_W-1:0]   r_qty;
    logic [TOTAL_W-1:0] r_subtotal;
    logic [ADDR_W:0]    r_item_count;
    logic               r_overflow;
    logic               r_rec_valid;
    logic [1:0]         r_rec_kind;
    logic               r_rec_last;
    logic [ADDR_W-1:0]  r_rec_index;
    logic [PRICE_W-1:0] r_rec_price;
    logic [QTY_W-1:0]   r_rec_qty;
    logic [TOTAL_W-1:0] r_rec_amount;

    logic [AMT_W-1:0]   w_amount;
    logic [TOTAL_W:0]   w_line_sum;
    logic               w_empty;
    logic               w_accept;
    logic               w_last_slot;
    logic               w_advance;

    assign w_amount    = AMT_W'(r_price) * AMT_W'(r_qty);
    assign w_line_sum  = {1'b0, r_subtotal} + (TOTAL_W + 1)'(w_amount);
    assign w_empty     = (r_price == '0) || (r_qty == '0);
    assign w_accept    = r_rec_valid && rec_ready;
    assign w_last_slot = (r_ptr == ADDR_W'(NUM_SLOTS - 1));
    assign w_advance   = ((r_state == S_EVAL) && w_empty) || ((r_state == S_EMIT) && w_accept);

`ifdef CART_CHECKOUT_TAX_EN
    // Restoring divider: shifts subtotal*tax_bp through a remainder against 10000, one bit per cycle.
    localparam int DIV_W = TOTAL_W + 14;
    localparam int CNT_W = $clog2(DIV_W + 1);

    logic [13:0]        r_tax_bp;
    logic [DIV_W-1:0]   r_div_q;
    logic [13:0]        r_div_rem;
    logic [CNT_W-1:0]   r_div_cnt;
    logic [14:0]        w_rem_shift;
    logic               w_rem_ge;
    logic [13:0]        w_rem_next;
    logic               w_tax_clip;
    logic [TOTAL_W-1:0] w_tax_sat;
    logic [TOTAL_W:0]   w_tax_sum;

    assign w_rem_shift = {r_div_rem, r_div_q[DIV_W-1]};
    assign w_rem_ge    = (w_rem_shift >= 15'd10000);
    assign w_rem_next  = w_rem_ge ? 14'(w_rem_shift - 15'd10000) : w_rem_shift[13:0];
    assign w_tax_clip  = |r_div_q[DIV_W-1:TOTAL_W];
    assign w_tax_sat   = w_tax_clip ? MAX_TOTAL : r_div_q[TOTAL_W-1:0];
    assign w_tax_sum   = {1'b0, r_subtotal} + {1'b0, w_tax_sat};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_price      <= '0;
            r_qty        <= '0;
            r_subtotal   <= '0;
            r_item_count <= '0;
            r_overflow   <= 1'b0;
            r_rec_valid  <= 1'b0;
            r_rec_kind   <= 2'd0;
            r_rec_last   <= 1'b0;
            r_rec_index  <= '0;
            r_rec_price  <= '0;
            r_rec_qty    <= '0;
            r_rec_amount <= '0;
`ifdef CART_CHECKOUT_TAX_EN
            r_tax_bp     <= '0;
            r_div_q      <= '0;
            r_div_rem    <= '0;
            r_div_cnt    <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_subtotal   <= '0;
                    r_item_count <= '0;
                    r_overflow   <= 1'b0;
                    r_ptr        <= '0;
`ifdef CART_CHECKOUT_TAX_EN
                    r_tax_bp     <= tax_bp;
`endif
                    r_state      <= S_READ;
                end
                S_READ: r_state <= S_WAIT;
                S_WAIT: begin
                    r_price <= slot_price;
                    r_qty   <= slot_qty;
                    r_state <= S_EVAL;
                end
                S_EVAL: if (!w_empty) begin
                    r_rec_valid  <= 1'b1;
                    r_rec_kind   <= 2'd0;
                    r_rec_last   <= 1'b0;
                    r_rec_index  <= r_ptr;
                    r_rec_price  <= r_price;
                    r_rec_qty    <= r_qty;
                    r_rec_amount <= TOTAL_W'(w_amount);
                    r_subtotal   <= w_line_sum[TOTAL_W] ? MAX_TOTAL : w_line_sum[TOTAL_W-1:0];
                    if (w_line_sum[TOTAL_W]) r_overflow <= 1'b1;
                    r_state      <= S_EMIT;
                end
                S_EMIT: if (w_accept) begin
                    r_rec_valid  <= 1'b0;
                    r_item_count <= r_item_count + (ADDR_W + 1)'(1);
                end
`ifdef CART_CHECKOUT_TAX_EN
                S_TAX: begin
                    if (!r_rec_valid) begin
                        if (r_div_cnt != CNT_W'(DIV_W)) begin
                            r_div_rem <= w_rem_next;
                            r_div_q   <= {r_div_q[DIV_W-2:0], w_rem_ge};
                            r_div_cnt <= r_div_cnt + CNT_W'(1);
                        end else begin
                            r_rec_valid  <= 1'b1;
                            r_rec_kind   <= 2'd1;
                            r_rec_last   <= 1'b0;
                            r_rec_index  <= '0;
                            r_rec_price  <= '0;
                            r_rec_qty    <= '0;
                            r_rec_amount <= w_tax_sat;
                            r_subtotal   <= w_tax_sum[TOTAL_W] ? MAX_TOTAL : w_tax_sum[TOTAL_W-1:0];
                            if (w_tax_clip || w_tax_sum[TOTAL_W]) r_overflow <= 1'b1;
                        end
                    end else if (w_accept) begin
                        r_rec_valid <= 1'b0;
                        r_state     <= S_TOTAL;
                    end
                end
`endif
                // First TOTAL cycle loads the record so rec_valid is low for a cycle after each acceptance.
                S_TOTAL: begin
                    if (!r_rec_valid) begin
                        r_rec_valid  <= 1'b1;
                        r_rec_kind   <= 2'd2;
                        r_rec_last   <= 1'b1;
                        r_rec_index  <= '0;
                        r_rec_price  <= '0;
                        r_rec_qty    <= '0;
                        r_rec_amount <= r_subtotal;
                    end else if (w_accept) begin
                        r_rec_valid <= 1'b0;
                        r_state     <= S_FIN;
                    end
                end
                S_FIN:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            if (w_advance) begin
                if (w_last_slot) begin
`ifdef CART_CHECKOUT_TAX_EN
                    r_div_q   <= DIV_W'(r_subtotal) * DIV_W'(r_tax_bp);
                    r_div_rem <= '0;
                    r_div_cnt <= '0;
                    r_state   <= S_TAX;
`else
                    r_state   <= S_TOTAL;
`endif
                end else begin
                    r_ptr   <= r_ptr + ADDR_W'(1);
                    r_state <= S_READ;
                end
            end
        end
    end

    assign busy       = (r_state != S_IDLE) && (r_state != S_FIN);
    assign done       = (r_state == S_FIN);
    assign slot_rd_en = (r_state == S_READ);
    assign slot_addr  = r_ptr;
    assign rec_valid  = r_rec_valid;
    assign rec_kind   = r_rec_kind;
    assign rec_last   = r_rec_last;
    assign rec_index  = r_rec_index;
    assign rec_price  = r_rec_price;
    assign rec_qty    = r_rec_qty;
    assign rec_amount = r_rec_amount;
    assign item_count = r_item_count;
    assign overflow   = r_overflow;
endmodule

// File: tb/tb_cart_checkout_reader.sv
// Scoreboard bench for cart_checkout_reader: expected records are queued at start and popped on each handshake.
module tb_cart_checkout_reader;
    localparam int NS = 5;
    localparam int AW = 3;
    localparam int PW = 16;
    localparam int QW = 8;
    localparam int TW = 24;
    localparam longint MAXV = (64'd1 << TW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          rec_ready = 1'b1;
    logic          busy, done, slot_rd_en, rec_valid, rec_last, overflow;
    logic [AW-1:0] slot_addr, rec_index;
    logic [PW-1:0] slot_price, rec_price;
    logic [QW-1:0] slot_qty, rec_qty;
    logic [1:0]    rec_kind;
    logic [TW-1:0] rec_amount;
    logic [AW:0]   item_count;
`ifdef CART_CHECKOUT_TAX_EN
    logic [13:0]   tax_bp = 14'd825;
`endif

    typedef struct packed {
        logic [1:0]    kind;
        logic          last;
        logic [AW-1:0] idx;
        logic [PW-1:0] price;
        logic [QW-1:0] qty;
        logic [TW-1:0] amt;
    } rec_t;

    rec_t          exp_q[$];
    int            n_checks = 0;
    int            n_pass = 0;
    int            done_cnt = 0;
    int            ready_mode = 0;
    int            stall_cnt = 0;
    logic [PW-1:0] mem_p[NS];
    logic [QW-1:0] mem_q[NS];
    logic [PW-1:0] rd_p;
    logic [QW-1:0] rd_q;
    logic          rd_vld = 1'b0;
    logic          prev_stall = 1'b0;
    rec_t          held;

    cart_checkout_reader #(
        .NUM_SLOTS(NS), .ADDR_W(AW), .PRICE_W(PW), .QTY_W(QW), .TOTAL_W(TW)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
`ifdef CART_CHECKOUT_TAX_EN
        .tax_bp(tax_bp),
`endif
        .busy(busy), .done(done), .slot_rd_en(slot_rd_en), .slot_addr(slot_addr),
        .slot_price(slot_price), .slot_qty(slot_qty), .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_kind(rec_kind), .rec_last(rec_last), .rec_index(rec_index), .rec_price(rec_price),
        .rec_qty(rec_qty), .rec_amount(rec_amount), .item_count(item_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Storage model: data valid only the cycle after the read strobe, junk otherwise.
    always @(posedge clk) begin
        rd_vld <= slot_rd_en;
        if (slot_rd_en) begin
            rd_p <= mem_p[slot_addr];
            rd_q <= mem_q[slot_addr];
        end
    end
    assign slot_price = rd_vld ? rd_p : 16'hBEEF;
    assign slot_qty   = rd_vld ? rd_q : 8'h5A;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    // Ready driver: mode 0 always ready, mode 1 holds ready low for 4 cycles per record.
    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) begin
            rec_ready = 1'b1;
            stall_cnt = 0;
        end else if (rec_valid) begin
            if (stall_cnt < 4) begin
                rec_ready = 1'b0;
                stall_cnt++;
            end else begin
                rec_ready = 1'b1;
                stall_cnt = 0;
            end
        end else begin
            rec_ready = 1'b0;
        end
    end

    always @(negedge clk) begin
        rec_t got;
        rec_t e;
        if (!reset) begin
            got = {rec_kind, rec_last, rec_index, rec_price, rec_qty, rec_amount};
            if (done) done_cnt++;
            if (prev_stall) check_val("stall_hold", {rec_valid, got}, {1'b1, held});
            if (rec_valid) check_val("no_read_while_valid", slot_rd_en, 1'b0);
            if (rec_valid && rec_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_rec", got, '0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("rec", got, e);
                    $display("rec kind=%0d idx=%0d price=%0d qty=%0d amt=%0d last=%0d (exp amt=%0d)",
                             rec_kind, rec_index, rec_price, rec_qty, rec_amount, rec_last, e.amt);
                end
            end
            prev_stall = rec_valid && !rec_ready;
            held = got;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic load5(input int p0, q0, p1, q1, p2, q2, p3, q3, p4, q4);
        mem_p[0] = PW'(p0); mem_q[0] = QW'(q0);
        mem_p[1] = PW'(p1); mem_q[1] = QW'(q1);
        mem_p[2] = PW'(p2); mem_q[2] = QW'(q2);
        mem_p[3] = PW'(p3); mem_q[3] = QW'(q3);
        mem_p[4] = PW'(p4); mem_q[4] = QW'(q4);
    endtask

    task automatic push_expected(output int n_items, output bit ov);
        longint sub = 0;
        longint amt;
        rec_t r;
        n_items = 0;
        ov = 1'b0;
        for (int i = 0; i < NS; i++) begin
            if (mem_p[i] != 0 && mem_q[i] != 0) begin
                amt = longint'(mem_p[i]) * longint'(mem_q[i]);
                r = {2'd0, 1'b0, AW'(i), mem_p[i], mem_q[i], TW'(amt)};
                exp_q.push_back(r);
                sub += amt;
                if (sub > MAXV) begin sub = MAXV; ov = 1'b1; end
                n_items++;
            end
        end
`ifdef CART_CHECKOUT_TAX_EN
        amt = (sub * longint'(tax_bp)) / 10000;
        if (amt > MAXV) begin amt = MAXV; ov = 1'b1; end
        r = {2'd1, 1'b0, AW'(0), PW'(0), QW'(0), TW'(amt)};
        exp_q.push_back(r);
        sub += amt;
        if (sub > MAXV) begin sub = MAXV; ov = 1'b1; end
`endif
        r = {2'd2, 1'b1, AW'(0), PW'(0), QW'(0), TW'(sub)};
        exp_q.push_back(r);
    endtask

    task automatic run_scan(input string name, input bit extra_start);
        int  n;
        bit  ov;
        int  dc0;
        bit  seen;
        push_expected(n, ov);
        dc0 = done_cnt;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check_val({name, "_first_rd"}, {busy, slot_rd_en, slot_addr}, {1'b1, 1'b1, AW'(0)});
        if (extra_start) begin
            repeat (5) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        seen = 1'b0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check_val({name, "_done_seen"}, seen, 1'b1);
        repeat (3) @(negedge clk);
        check_val({name, "_done_once"}, done_cnt - dc0, 1);
        check_val({name, "_queue_empty"}, exp_q.size(), 0);
        check_val({name, "_item_count"}, item_count, n);
        check_val({name, "_overflow"}, overflow, ov);
        check_val({name, "_idle"}, busy, 1'b0);
        $display("scan %s items=%0d overflow=%0d", name, item_count, overflow);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  dc0;
        bit  found;
        int  n;
        bit  ov;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_ctl", {busy, done, slot_rd_en, slot_addr, rec_valid, item_count, overflow}, '0);
        check_val("reset_rec", {rec_kind, rec_last, rec_index, rec_price, rec_qty, rec_amount}, '0);
        reset = 1'b0;

        load5(100, 1, 50, 3, 0, 0, 0, 0, 0, 0);
        run_scan("basic", 1'b0);
        load5(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_scan("all_empty", 1'b0);
        load5(100, 1, 50, 3, 0, 0, 0, 0, 0, 0);
        ready_mode = 1;
        run_scan("stalled", 1'b0);
        ready_mode = 0;
        load5(0, 5, 7, 0, 3, 4, 0, 0, 9, 9);
        run_scan("sparse_restart_ignored", 1'b1);
        load5(1, 1, 2, 2, 3, 3, 4, 4, 5, 5);
        run_scan("full", 1'b0);
        load5(65535, 255, 65535, 255, 0, 0, 0, 0, 0, 0);
        run_scan("saturate", 1'b0);
        load5(100, 1, 50, 3, 0, 0, 0, 0, 0, 0);
        run_scan("overflow_cleared", 1'b0);

        // Reset while the idx1 line record is being offered.
        push_expected(n, ov);
        dc0 = done_cnt;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (rec_valid && rec_kind == 2'd0 && rec_index == AW'(1)) found = 1'b1;
        end
        check_val("mid_emit_reached", found, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check_val("midrst_ctl", {busy, done, slot_rd_en, slot_addr, rec_valid, item_count, overflow}, '0);
        check_val("midrst_rec", {rec_kind, rec_last, rec_index, rec_price, rec_qty, rec_amount}, '0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        repeat (5) @(negedge clk);
        check_val("midrst_no_done", done_cnt - dc0, 0);
        run_scan("after_reset", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
